tab_hash_sequencer: RTL and testbench
=====================================

Name: tab_hash_sequencer

Overview:
- Sequences the quad-read static tabulation table to compute four independent tabulation hashes of a key, one key chunk per cycle.
- Shares the single table between NREQ requesters using a round-robin arbiter.
- Sits between the key sources and the hash consumer. It drives the table's read address and XOR-accumulates the four data words the table returns at consecutive locations.
- Table layout: entry (c*256 + byte)*4 + k holds the hash-function-k value for chunk c, byte value byte.

Parameters:
- NREQ, 2, number of requesters (≥1).
- KEY_CHUNKS, 4, number of 8-bit chunks per key.
- DBITS, 32, hash word width (equals table Dbits).
- TADDR_W, $clog2(KEY_CHUNKS*256*4), table address width; the table is sized with Nloc = KEY_CHUNKS*1024.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester key valid.
- req_key  in  NREQ*KEY_CHUNKS*8  keys, requester i at slice i; chunk 0 is the LSByte.
- req_ready  out  NREQ  one-hot grant/accept.
- tbl_addr  out  TADDR_W  table read address.
- tbl_data1..tbl_data4  in  DBITS each  asynchronous table outputs at tbl_addr+0..+3.
- out_valid  out  1  hash result valid.
- out_ready  in  1  consumer accepts.
- out_hash  out  4*DBITS  {fn3,fn2,fn1,fn0}; fn0 is in the LSBs.
- out_id  out  $clog2(NREQ) (min 1)  index of the requester that produced out_hash.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, chunk counter=0, accumulators=0.
  - out_valid=0, out_hash=0, out_id=0, req_ready=0, tbl_addr=0.
  - RR pointer set so requester 0 has highest priority.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready is asserted combinationally, one-hot, for the highest-priority valid requester. Search starts at (last_grant+1) mod NREQ.
  - A handshake occurs when req_valid[i] & req_ready[i]. On that clock edge:
    - latch key and id;
    - clear the 4 accumulators and set chunk=0;
    - update the RR pointer to i;
    - go to RUN.
  - tbl_addr=0.
- RUN:
  - tbl_addr = {chunk, key[chunk*8 +: 8], 2'b00}, driven from registers only (no combinational path from req_*).
  - Each cycle, acc_k ^= tbl_data(k+1) and chunk increments.
  - When chunk==KEY_CHUNKS-1, perform the final XOR, then go to DONE.
- DONE:
  - out_valid=1; out_hash and out_id are held stable while out_ready=0.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
- req_ready=0 in RUN and DONE; no new key is accepted until the result is consumed.
- Latency: handshake at edge T → out_valid high after edge T+KEY_CHUNKS (KEY_CHUNKS RUN cycles). Minimum period per hash is KEY_CHUNKS+2 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- Width rule: the XOR is bitwise at DBITS. No carries, no truncation.
- Boundary conditions:
  - req_valid deasserted without a grant: no effect; requests are not sticky.
  - Simultaneous valids: only one grant per IDLE cycle.
  - NREQ=1: arbiter degenerates; out_id is constant 0.
  - Reset mid-RUN or mid-DONE: immediate return to reset values; the in-flight hash is dropped and out_valid falls asynchronously.
  - Key byte 0xFF in the last chunk: tbl_addr reaches KEY_CHUNKS*1024-4. The +3 port stays in range; there is no wrap.

Decomposition:
- Package tab_hash_pkg holds:
  - localparam CHUNK_BITS=8 and ENTRIES_PER_CHUNK=256;
  - typedef enum logic [1:0] {IDLE,RUN,DONE} seq_state_t;
  - a function computing the table address from chunk and byte.
- One sub-module, rr_arbiter (NREQ, one-hot grant, pointer update on accept), is natural and reusable.
- Integration test: a top wraps tab_hash_sequencer plus the existing static table.

Test Plan:
- Identity init file (T[a]=a), KEY_CHUNKS=4, requester 0 key 0x00000000 → 4 RUN cycles, out_hash all four fn = 0x00000000, out_id=0, out_valid exactly 4 cycles after accept.
- Key 0x00000001 → tbl_addr sequence 4,1024,2048,3072; fn0..fn3 = 0x4 each.
- Key 0xFFFFFFFF → tbl_addr 1020,2044,3068,4092 (top entry, no overflow); all fn = 0x0.
- Both requesters continuously valid with distinct keys, out_ready=1 → grants alternate 0,1,0,1; out_id matches; results match the reference model.
- out_ready held low 5 cycles in DONE → out_valid and out_hash stable, req_ready stays 0, no new accept; accept follows in the cycle after IDLE is re-entered.
- rst_n pulsed low during the 2nd RUN cycle → out_valid=0, tbl_addr=0 immediately; the next request yields a correct fresh hash with no stale accumulator contribution.

Source files
------------

// File: rtl/tab_hash_pkg.sv
// Shared types and address helper for the tabulation-hash sequencer.
// Table entry (chunk*256 + byte)*4 + k holds hash function k's value.
package tab_hash_pkg;

  localparam int CHUNK_BITS        = 8;
  localparam int ENTRIES_PER_CHUNK = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Base address of the four consecutive words for (chunk, byte).
  function automatic int unsigned tbl_index(input int unsigned chunk,
                                            input int unsigned byte_v);
    return (chunk * ENTRIES_PER_CHUNK + byte_v) * 4;
  endfunction

endpackage

// File: rtl/tab_hash_sequencer_if.sv
// Bundles requester, table and consumer signals of the tabulation-hash sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and a valid that drops before ready is
// simply withdrawn (requests are not sticky).
interface tab_hash_sequencer_if #(
  parameter int NREQ       = 2,
  parameter int KEY_CHUNKS = 4,
  parameter int DBITS      = 32,
  parameter int TADDR_W    = $clog2(KEY_CHUNKS * 256 * 4),
  parameter int ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]              req_valid;
  logic [NREQ*KEY_CHUNKS*8-1:0] req_key;
  logic [NREQ-1:0]              req_ready;
  logic [TADDR_W-1:0]           tbl_addr;
  logic [DBITS-1:0]             tbl_data1;
  logic [DBITS-1:0]             tbl_data2;
  logic [DBITS-1:0]             tbl_data3;
  logic [DBITS-1:0]             tbl_data4;
  logic                         out_valid;
  logic                         out_ready;
  logic [4*DBITS-1:0]           out_hash;
  logic [ID_W-1:0]              out_id;

  modport slave (
    input  req_valid, req_key, tbl_data1, tbl_data2, tbl_data3, tbl_data4, out_ready,
    output req_ready, tbl_addr, out_valid, out_hash, out_id
  );

  modport master (
    output req_valid, req_key, tbl_data1, tbl_data2, tbl_data3, tbl_data4, out_ready,
    input  req_ready, tbl_addr, out_valid, out_hash, out_id
  );
endinterface

// File: rtl/tab_hash_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last accepted
// requester; the pointer only moves when a grant is actually accepted.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    cand     = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % NREQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_id_o    = cand;
      end
    end
  end

  assign ptr_d = accept_i ? gnt_id_o : ptr_q;

  // Pointer resets to the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= ID_W'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tab_hash_sequencer.sv
// Computes four tabulation hashes of an arbitrated key, one 8-bit chunk per
// cycle, by XOR-accumulating the four table words returned for each chunk.
module tab_hash_sequencer
  import tab_hash_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int KEY_CHUNKS = 4,
  parameter int DBITS      = 32,
  parameter int TADDR_W    = $clog2(KEY_CHUNKS * 256 * 4)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tab_hash_sequencer_if.slave  bus,
  output seq_state_t           dbg_state_o
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW   = KEY_CHUNKS * CHUNK_BITS;
  localparam int CW   = (KEY_CHUNKS > 1) ? $clog2(KEY_CHUNKS) : 1;
  localparam int HW   = 4 * DBITS;

  seq_state_t      state_q, state_d;
  logic [CW-1:0]   chunk_q, chunk_d;
  logic [KW-1:0]   key_q, key_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [HW-1:0]   acc_q, acc_d;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            arb_en;
  logic            accept;
  logic [KW-1:0]   key_sel;
  logic [7:0]      cur_byte;

  // Grants are withheld while reset is asserted so req_ready reads 0 then.
  assign arb_en = (state_q == IDLE) && rst_n;
  assign accept = |(bus.req_valid & gnt);

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.req_valid),
    .en_i     (arb_en),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    key_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == ID_W'(i)) key_sel = bus.req_key[i*KW +: KW];
    end
  end

  // Address is formed only from latched key/chunk, never from req_* inputs.
  always_comb begin
    cur_byte = '0;
    for (int c = 0; c < KEY_CHUNKS; c++) begin
      if (chunk_q == CW'(c)) cur_byte = key_q[c*CHUNK_BITS +: CHUNK_BITS];
    end
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    key_d   = key_q;
    id_d    = id_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          key_d   = key_sel;
          id_d    = gnt_id;
          acc_d   = '0;
          chunk_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q ^ {bus.tbl_data4, bus.tbl_data3, bus.tbl_data2, bus.tbl_data1};
        chunk_d = chunk_q + 1'b1;
        if (chunk_q == CW'(KEY_CHUNKS - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chunk_q <= '0;
      key_q   <= '0;
      id_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      key_q   <= key_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.tbl_addr  = (state_q == RUN)
                         ? TADDR_W'(tbl_index(32'(chunk_q), 32'(cur_byte)))
                         : '0;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_hash  = acc_q;
  assign bus.out_id    = id_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tab_hash_sequencer.sv
// Bench for tab_hash_sequencer: a table model drives tbl_data*, and a
// per-cycle compare process checks arbitration, addresses, timing and hashes.
module tb_tab_hash_sequencer;
  import tab_hash_pkg::*;

  localparam int NREQ    = 2;
  localparam int KC      = 4;
  localparam int DBITS   = 32;
  localparam int TADDR_W = 12;
  localparam int ID_W    = 1;
  localparam int KW      = KC * 8;
  localparam int HW      = 4 * DBITS;

  logic       clk;
  logic       rst_n;
  seq_state_t dbg_state;

  tab_hash_sequencer_if #(.NREQ(NREQ), .KEY_CHUNKS(KC), .DBITS(DBITS), .TADDR_W(TADDR_W)) bus ();

  tab_hash_sequencer #(.NREQ(NREQ), .KEY_CHUNKS(KC), .DBITS(DBITS), .TADDR_W(TADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- table model ----------------
  logic [DBITS-1:0] tbl [4096];
  assign bus.tbl_data1 = tbl[bus.tbl_addr];
  assign bus.tbl_data2 = tbl[bus.tbl_addr + 12'd1];
  assign bus.tbl_data3 = tbl[bus.tbl_addr + 12'd2];
  assign bus.tbl_data4 = tbl[bus.tbl_addr + 12'd3];

  function automatic logic [HW-1:0] model_hash(input logic [KW-1:0] key);
    logic [HW-1:0] h;
    h = '0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < KC; c++)
        h[k*DBITS +: DBITS] ^= tbl[(c*256 + int'(key[c*8 +: 8]))*4 + k];
    return h;
  endfunction

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [HW-1:0]      exp_q[$];
  logic [ID_W-1:0]    exp_id_q[$];
  logic [TADDR_W-1:0] addr_log[$];
  int                 grant_q[$];
  logic [KW-1:0]      cur_key;
  logic [HW-1:0]      last_hash;
  logic [NREQ-1:0]    exp_rdy;
  bit                 busy = 1'b0;
  int                 cyc = 0;
  int                 acc_cyc = 0;
  int                 last_gnt = NREQ - 1;
  int                 exp_g;
  int                 n;
  int                 done_cnt = 0;
  int                 acc_cnt [NREQ];

  initial for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ready", 128'(bus.req_ready), 128'(0));
      chk("rst_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_addr",  128'(bus.tbl_addr),  128'(0));
      chk("rst_hash",  128'(bus.out_hash),  128'(0));
      chk("rst_id",    128'(bus.out_id),    128'(0));
      chk("rst_state", 128'(dbg_state),     128'(IDLE));
      exp_q.delete();
      exp_id_q.delete();
      busy     = 1'b0;
      last_gnt = NREQ - 1;
    end else if (!busy) begin
      exp_g = -1;
      for (int off = 1; off <= NREQ; off++)
        if (exp_g < 0 && bus.req_valid[(last_gnt + off) % NREQ]) exp_g = (last_gnt + off) % NREQ;
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      chk("grant",      128'(bus.req_ready), 128'(exp_rdy));
      chk("idle_valid", 128'(bus.out_valid), 128'(0));
      chk("idle_addr",  128'(bus.tbl_addr),  128'(0));
      if (exp_g >= 0) begin
        cur_key = bus.req_key[exp_g*KW +: KW];
        exp_q.push_back(model_hash(cur_key));
        exp_id_q.push_back(ID_W'(exp_g));
        busy     = 1'b1;
        acc_cyc  = cyc;
        last_gnt = exp_g;
        acc_cnt[exp_g]++;
        grant_q.push_back(exp_g);
      end
    end else begin
      n = cyc - acc_cyc;
      chk("busy_ready", 128'(bus.req_ready), 128'(0));
      if (n <= KC) begin
        chk("run_valid", 128'(bus.out_valid), 128'(0));
        chk("run_addr", 128'(bus.tbl_addr), 128'(((n - 1)*256 + int'(cur_key[(n - 1)*8 +: 8]))*4));
        addr_log.push_back(bus.tbl_addr);
      end else begin
        chk("done_valid", 128'(bus.out_valid), 128'(1));
        chk("done_hash",  128'(bus.out_hash),  128'(exp_q[0]));
        chk("done_id",    128'(bus.out_id),    128'(exp_id_q[0]));
        chk("done_addr",  128'(bus.tbl_addr),  128'(0));
        if (bus.out_ready) begin
          last_hash = bus.out_hash;
          void'(exp_q.pop_front());
          void'(exp_id_q.pop_front());
          busy = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks (all return at posedge + 1) ----------------
  task automatic wait_accept(input int id, input int start);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_cnt[id] != start) break;
    end
    chk("accept_timeout", 128'(acc_cnt[id] != start), 128'(1));
    #1;
  endtask

  task automatic send(input int id, input logic [KW-1:0] key);
    int start;
    start = acc_cnt[id];
    bus.req_key[id*KW +: KW] = key;
    bus.req_valid[id] = 1'b1;
    wait_accept(id, start);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    chk("done_timeout", 128'(done_cnt >= target), 128'(1));
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 128'(busy), 128'(0));
    #1;
  endtask

  task automatic run_directed(input logic [KW-1:0] key, input logic [HW-1:0] exp_hash,
                              input int a0, input int a1, input int a2, input int a3);
    int d;
    int exp_a [4];
    exp_a = '{a0, a1, a2, a3};
    chk("model_pin", 128'(model_hash(key)), 128'(exp_hash));
    addr_log.delete();
    d = done_cnt;
    send(0, key);
    wait_done(d + 1);
    chk("lit_hash", 128'(last_hash), 128'(exp_hash));
    chk("lit_addr_count", 128'(addr_log.size()), 128'(4));
    if (addr_log.size() == 4)
      for (int j = 0; j < 4; j++) chk("lit_addr", 128'(addr_log[j]), 128'(exp_a[j]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d;
    int start1;
    int exp_seq [4];
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_key   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) tbl[i] = DBITS'(i);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity table: hand-derived hashes and address walks.
    run_directed(32'h0000_0000, 128'h0, 0, 1024, 2048, 3072);
    run_directed(32'h0000_0001, {4{32'h0000_0004}}, 4, 1024, 2048, 3072);
    run_directed(32'hFFFF_FFFF, 128'h0, 1020, 2044, 3068, 4092);

    for (int i = 0; i < 4096; i++) tbl[i] = $urandom();

    // Consumer stalls 5 cycles in DONE while requester 1 waits.
    bus.out_ready = 1'b0;
    d = done_cnt;
    start1 = acc_cnt[1];
    send(0, $urandom());
    bus.req_key[KW +: KW] = $urandom();
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_accept(1, start1);
    bus.req_valid[1] = 1'b0;
    wait_done(d + 2);

    // Reset pulse during the second RUN cycle.
    start1 = acc_cnt[0];
    bus.req_key[0 +: KW] = $urandom();
    bus.req_valid[0] = 1'b1;
    wait_accept(0, start1);
    bus.req_valid[0] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bus.out_valid), 128'(0));
    chk("async_rst_addr",  128'(bus.tbl_addr),  128'(0));
    chk("async_rst_hash",  128'(bus.out_hash),  128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    d = done_cnt;
    send(0, $urandom());
    wait_done(d + 1);

    // Both requesters continuously valid: grants alternate, starting after 0.
    grant_q.delete();
    bus.req_valid = '1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 bus.req_key = {$urandom(), $urandom()};
      if (grant_q.size() >= 4) break;
    end
    bus.req_valid = '0;
    wait_idle();
    exp_seq = '{1, 0, 1, 0};
    chk("alt_count", 128'(grant_q.size() >= 4), 128'(1));
    if (grant_q.size() >= 4)
      for (int j = 0; j < 4; j++) chk("alt_grant", 128'(grant_q[j]), 128'(exp_seq[j]));

    // Random traffic with random consumer back-pressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid = NREQ'($urandom_range(0, 3));
      bus.req_key   = {$urandom(), $urandom()};
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
